// File: rtl/gf_inv_pipe.sv
// gf_inv_pipe: pipelined multiplicative inverse over GF(2^W), LANES lanes per beat.
// Each lane maps a -> a^-1 (0 -> 0) in polynomial basis:
//   W=2: x^2+x+1, W=4: x^4+x+1, W=8: x^8+x^4+x^3+x+1.
// The inverse is formed combinationally at the input as a^(2^W-2) and then
// carried through STAGES register stages. A stall (out_valid & ~out_ready)
// freezes every stage; bubbles are not collapsed.
// Optional macro GF_INV_ZERO_FLAG_EN adds out_zero, a per-lane flag marking
// a zero input, pipelined alongside the data.
module gf_inv_pipe #(
  parameter int W      = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data
`ifdef GF_INV_ZERO_FLAG_EN
  ,
  output logic [LANES-1:0]   out_zero
`endif
);

  // Only the three supported field widths and 1..4 stages elaborate.
  generate
    if (!(W == 2 || W == 4 || W == 8)) begin : g_bad_w
      $error("gf_inv_pipe: W must be 2, 4 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("gf_inv_pipe: STAGES must be in 1..4");
    end
  endgenerate

  // Reduction polynomial without its x^W term.
  localparam logic [W-1:0] POLY = (W == 8) ? W'(8'h1B) : W'(2'b11);
  localparam logic [W-1:0] ONE  = W'(1'b1);

  // Shift-and-add multiply with interleaved reduction.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] acc;
    logic [W-1:0] x;
    acc = {W{1'b0}};
    x   = a;
    for (int i = 0; i < W; i++) begin
      acc = b[i] ? (acc ^ x) : acc;
      x   = x[W-1] ? ({x[W-2:0], 1'b0} ^ POLY) : {x[W-2:0], 1'b0};
    end
    return acc;
  endfunction

  // a^-1 = a^(2^W-2) = prod_{k=1..W-1} a^(2^k); zero falls out as zero.
  function automatic logic [W-1:0] gf_inv(input logic [W-1:0] a);
    logic [W-1:0] p;
    logic [W-1:0] r;
    p = a;
    r = ONE;
    for (int k = 1; k < W; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  valid_d;
  logic [LANES*W-1:0] data_q [STAGES];
  logic [LANES*W-1:0] data_d [STAGES];
  logic [LANES*W-1:0] inv_s;
  logic               advance_s;
`ifdef GF_INV_ZERO_FLAG_EN
  logic [LANES-1:0]   zero_q [STAGES];
  logic [LANES-1:0]   zero_d [STAGES];
  logic [LANES-1:0]   zero_s;
`endif

  // Whole pipeline moves unless the output beat is presented and refused.
  assign advance_s = out_ready | ~valid_q[STAGES-1];
  assign in_ready  = advance_s;
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
`ifdef GF_INV_ZERO_FLAG_EN
  assign out_zero  = zero_q[STAGES-1];
`endif

  // Per-lane inverse (and zero flag) of the incoming beat; lanes never interact.
  always_comb begin
    inv_s = {(LANES*W){1'b0}};
`ifdef GF_INV_ZERO_FLAG_EN
    zero_s = {LANES{1'b0}};
`endif
    for (int i = 0; i < LANES; i++) begin
      inv_s[i*W +: W] = gf_inv(in_data[i*W +: W]);
`ifdef GF_INV_ZERO_FLAG_EN
      zero_s[i] = (in_data[i*W +: W] == {W{1'b0}});
`endif
    end
  end

  // Next-state of the stage registers: shift all on advance, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef GF_INV_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    if (advance_s) begin
      valid_d[0] = in_valid;
      data_d[0]  = inv_s;
`ifdef GF_INV_ZERO_FLAG_EN
      zero_d[0]  = zero_s;
`endif
      for (int s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
`ifdef GF_INV_ZERO_FLAG_EN
        zero_d[s]  = zero_q[s-1];
`endif
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
`ifdef GF_INV_ZERO_FLAG_EN
      zero_d  = zero_q;
`endif
    end
  end

  // Stage registers; synchronous reset discards in-flight beats and zeroes data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {STAGES{1'b0}};
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= {(LANES*W){1'b0}};
`ifdef GF_INV_ZERO_FLAG_EN
        zero_q[s] <= {LANES{1'b0}};
`endif
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef GF_INV_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_gf_inv_pipe.sv
// tb_gf_inv_pipe: scoreboard bench for gf_inv_pipe with three configurations
// (W8/L4/S2, W4/L2/S3, W2/L1/S1). Expected beats come from a brute-force
// field-inverse search; zero flags are checked when GF_INV_ZERO_FLAG_EN is set.
module tb_gf_inv_pipe;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
  logic [31:0] d8_in_data, d8_out_data;
  logic [3:0]  d8_out_zero;
  logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
  logic [7:0]  d4_in_data, d4_out_data;
  logic [1:0]  d4_out_zero;
  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [1:0]  d2_in_data, d2_out_data;
  logic [0:0]  d2_out_zero;

  logic [31:0] q8[$];
  logic [3:0]  qz8[$];
  logic [7:0]  q4[$];
  logic [1:0]  q2[$];
  int          acc8;

  gf_inv_pipe #(.W(8), .LANES(4), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .in_data(d8_in_data), .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .out_data(d8_out_data)
`ifdef GF_INV_ZERO_FLAG_EN
    , .out_zero(d8_out_zero)
`endif
  );
  gf_inv_pipe #(.W(4), .LANES(2), .STAGES(3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .in_data(d4_in_data), .out_valid(d4_out_valid), .out_ready(d4_out_ready),
    .out_data(d4_out_data)
`ifdef GF_INV_ZERO_FLAG_EN
    , .out_zero(d4_out_zero)
`endif
  );
  gf_inv_pipe #(.W(2), .LANES(1), .STAGES(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_data(d2_out_data)
`ifdef GF_INV_ZERO_FLAG_EN
    , .out_zero(d2_out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Carry-less product, then reduce modulo the full polynomial.
  function automatic int unsigned ref_mul(int unsigned a, int unsigned b, int w, int unsigned poly);
    int unsigned p = 0;
    for (int i = 0; i < w; i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 2*w-2; i >= w; i--)
      if (((p >> i) & 1) != 0) p = p ^ (poly << (i - w));
    return p;
  endfunction

  // Search for the element whose product with a is 1; 0 maps to 0.
  function automatic int unsigned ref_inv(int unsigned a, int w, int unsigned poly);
    if (a == 0) return 0;
    for (int unsigned b = 1; b < (32'd1 << w); b++)
      if (ref_mul(a, b, w, poly) == 1) return b;
    return 0;
  endfunction

  function automatic logic [31:0] ref_beat(logic [31:0] d, int w, int lanes, int unsigned poly);
    logic [31:0] r = 32'd0;
    int unsigned a;
    int unsigned mask = (32'd1 << w) - 1;
    for (int i = 0; i < lanes; i++) begin
      a = (d >> (i*w)) & mask;
      r = r | (ref_inv(a, w, poly) << (i*w));
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_zero8(logic [31:0] d);
    logic [3:0] z = 4'd0;
    for (int i = 0; i < 4; i++) z[i] = (((d >> (i*8)) & 32'hFF) == 32'd0);
    return z;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- input monitor: push expectations ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (d8_in_valid && d8_in_ready) begin
        q8.push_back(ref_beat(d8_in_data, 8, 4, 32'h11B));
        qz8.push_back(ref_zero8(d8_in_data));
        acc8++;
      end
      if (d4_in_valid && d4_in_ready) q4.push_back(8'(ref_beat({24'd0, d4_in_data}, 4, 2, 32'h13)));
      if (d2_in_valid && d2_in_ready) q2.push_back(2'(ref_beat({30'd0, d2_in_data}, 2, 1, 32'h7)));
    end
  end

  // ---------------- output monitors: pop and compare ----------------
  bit          stall_prev;
  logic [31:0] prev_data;
  logic [3:0]  prev_zero;
  logic [31:0] e8;
  logic [3:0]  ez8;
  always @(negedge clk) begin
    if (!rst) begin
      chk("d8_in_ready", {31'd0, d8_in_ready}, {31'd0, (d8_out_ready || !d8_out_valid)});
      if (stall_prev) begin
        chk("d8_stall_valid", {31'd0, d8_out_valid}, 32'd1);
        chk("d8_stall_data", d8_out_data, prev_data);
`ifdef GF_INV_ZERO_FLAG_EN
        chk("d8_stall_zero", {28'd0, d8_out_zero}, {28'd0, prev_zero});
`endif
      end
      if (d8_out_valid && d8_out_ready) begin
        if (q8.size() == 0) begin
          chk("d8_unexpected_beat", d8_out_data, 32'hXXXX_XXXX);
        end else begin
          e8  = q8.pop_front();
          ez8 = qz8.pop_front();
          chk("d8_data", d8_out_data, e8);
`ifdef GF_INV_ZERO_FLAG_EN
          chk("d8_zero", {28'd0, d8_out_zero}, {28'd0, ez8});
`endif
        end
      end
    end
    stall_prev = !rst && d8_out_valid && !d8_out_ready;
    prev_data  = d8_out_data;
    prev_zero  = d8_out_zero;
  end

  always @(negedge clk) begin
    if (!rst && d4_out_valid && d4_out_ready) begin
      if (q4.size() == 0) chk("d4_unexpected_beat", {24'd0, d4_out_data}, 32'hXXXX_XXXX);
      else chk("d4_data", {24'd0, d4_out_data}, {24'd0, q4.pop_front()});
    end
    if (!rst && d2_out_valid && d2_out_ready) begin
      if (q2.size() == 0) chk("d2_unexpected_beat", {30'd0, d2_out_data}, 32'hXXXX_XXXX);
      else chk("d2_data", {30'd0, d2_out_data}, {30'd0, q2.pop_front()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on dut8 and hold it until it transfers.
  task automatic send8(input logic [31:0] d);
    int start = acc8;
    int guard = 0;
    d8_in_data  = d;
    d8_in_valid = 1'b1;
    do begin
      tick();
      guard++;
    end while (acc8 == start && guard < 100);
    if (acc8 == start) chk("d8_send_timeout", 32'd0, 32'd1);
    d8_in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd8();
    logic [31:0] v;
    v = $urandom;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 7) == 0) v[i*8 +: 8] = 8'h00;
    return v;
  endfunction

  logic [1:0]  exp2 [4];
  logic [31:0] held;
  int          guard;

  initial begin
    n_cmp = 0; n_fail = 0; acc8 = 0;
    rst = 1'b1;
    d8_in_valid = 1'b0; d8_in_data = 32'd0; d8_out_ready = 1'b1;
    d4_in_valid = 1'b0; d4_in_data = 8'd0;  d4_out_ready = 1'b1;
    d2_in_valid = 1'b0; d2_in_data = 2'd0;  d2_out_ready = 1'b1;
    exp2[0] = 2'd0; exp2[1] = 2'd1; exp2[2] = 2'd3; exp2[3] = 2'd2;
    tick(); tick();
    chk("rst_out_valid", {31'd0, d8_out_valid}, 32'd0);
    chk("rst_out_data", d8_out_data, 32'd0);
    chk("rst_in_ready", {31'd0, d8_in_ready}, 32'd1);
    rst = 1'b0;

    // W=8 known vector: exactly two cycles of latency, valid for one cycle.
    d8_in_data = 32'h5301_0002; d8_in_valid = 1'b1;
    tick(); d8_in_valid = 1'b0;
    chk("lat_cycle1_valid", {31'd0, d8_out_valid}, 32'd0);
    tick();
    chk("lat_cycle2_valid", {31'd0, d8_out_valid}, 32'd1);
    chk("lat_cycle2_data", d8_out_data, 32'hCA01_008D);
    tick();
    chk("lat_cycle3_valid", {31'd0, d8_out_valid}, 32'd0);

`ifdef GF_INV_ZERO_FLAG_EN
    // Zero flag alignment with its data beat.
    d8_in_data = 32'h0011_00FF; d8_in_valid = 1'b1;
    tick(); d8_in_valid = 1'b0;
    tick();
    chk("zflag_valid", {31'd0, d8_out_valid}, 32'd1);
    chk("zflag_bits", {28'd0, d8_out_zero}, 32'h0000_000A);
    tick();
`endif

    // W=2: consecutive inputs give consecutive outputs.
    for (int i = 0; i < 4; i++) begin
      d2_in_data = 2'(i); d2_in_valid = 1'b1;
      tick();
      chk("w2_tput_valid", {31'd0, d2_out_valid}, 32'd1);
      chk("w2_tput_data", {30'd0, d2_out_data}, {30'd0, exp2[i]});
    end
    d2_in_valid = 1'b0;
    tick();
    chk("w2_tput_end", {31'd0, d2_out_valid}, 32'd0);

    // W=4 known vector, then all 16 values in each lane.
    d4_in_data = 8'h20; d4_in_valid = 1'b1;
    tick(); d4_in_valid = 1'b0;
    tick(); tick();
    chk("w4_known_valid", {31'd0, d4_out_valid}, 32'd1);
    chk("w4_known_data", {24'd0, d4_out_data}, 32'h0000_0090);
    for (int i = 0; i < 16; i++) begin
      d4_in_data = {4'(15 - i), 4'(i)}; d4_in_valid = 1'b1;
      tick();
    end
    d4_in_valid = 1'b0;

    // Stall: 8 beats streamed, output refused for 5 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send8(rnd8());
      end
      begin
        guard = 0;
        while (!d8_out_valid && guard < 50) begin tick(); guard++; end
        chk("stall_wait_valid", {31'd0, d8_out_valid}, 32'd1);
        held = d8_out_data;
        d8_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          chk("stall_in_ready", {31'd0, d8_in_ready}, 32'd0);
          chk("stall_hold_data", d8_out_data, held);
        end
        d8_out_ready = 1'b1;
      end
    join
    guard = 0;
    while (q8.size() != 0 && guard < 50) begin tick(); guard++; end
    chk("stall_drain_left", 32'(q8.size()), 32'd0);

    // Reset with two beats in flight.
    send8(rnd8());
    send8(rnd8());
    rst = 1'b1;
    q8.delete(); qz8.delete(); q4.delete(); q2.delete();
    tick();
    chk("midrst_out_valid", {31'd0, d8_out_valid}, 32'd0);
    chk("midrst_out_data", d8_out_data, 32'd0);
    chk("midrst_in_ready", {31'd0, d8_in_ready}, 32'd1);
`ifdef GF_INV_ZERO_FLAG_EN
    chk("midrst_out_zero", {28'd0, d8_out_zero}, 32'd0);
`endif
    rst = 1'b0;
    repeat (6) tick();

    // Random traffic with random backpressure on all three instances.
    for (int c = 0; c < 400; c++) begin
      d8_in_valid  = ($urandom_range(0, 9) < 7);
      d8_in_data   = rnd8();
      d8_out_ready = ($urandom_range(0, 9) < 6);
      d4_in_valid  = ($urandom_range(0, 9) < 7);
      d4_in_data   = 8'($urandom);
      d4_out_ready = ($urandom_range(0, 9) < 6);
      d2_in_valid  = ($urandom_range(0, 9) < 7);
      d2_in_data   = 2'($urandom);
      d2_out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    d8_in_valid = 1'b0; d4_in_valid = 1'b0; d2_in_valid = 1'b0;
    d8_out_ready = 1'b1; d4_out_ready = 1'b1; d2_out_ready = 1'b1;
    guard = 0;
    while ((q8.size() + q4.size() + q2.size()) != 0 && guard < 50) begin tick(); guard++; end
    chk("final_drain_q8", 32'(q8.size()), 32'd0);
    chk("final_drain_q4", 32'(q4.size()), 32'd0);
    chk("final_drain_q2", 32'(q2.size()), 32'd0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
